mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
//   Multiply uses 32 shift-add steps and divide uses 32 restoring
//   shift-subtract steps. Signed operations run on magnitudes and are
//   sign-corrected in FIN. MTHI/MTLO write HI/LO directly from IDLE.
//
//   Timing: the accept edge is edge 1, edges 2..33 run the iterations and
//   edge 34 (leaving FIN) writes Hi/Lo. Done is high for the single cycle
//   after edge 34, and a new Start is accepted during that cycle.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   OperandA in  32  rs value: multiplicand, dividend, MTHI/MTLO source
//   OperandB in  32  multiplier or divisor
//   Start    in   1  request, sampled only while idle
//   Op       in   3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV,
//                    100 MTHI, 101 MTLO, 110/111 no-op
//   Busy     out  1  iterative operation in progress
//   Done     out  1  one-cycle pulse after the HI/LO update
//   Hi       out 32  HI register
//   Lo       out 32  LO register
// ---------------------------------------------------------------------------
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        Start,
  input  logic [2:0]  Op,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Operation context captured at accept
  logic        div_q;     // 1: divide, 0: multiply
  logic        neg_q;     // negate product / quotient in FIN
  logic        rsign_q;   // negate remainder in FIN (dividend was negative)
  logic        dz_q;      // divisor was zero
  logic [31:0] a_q;       // original dividend, reported as HI on divide by zero
  logic [31:0] b_q;       // magnitude of multiplicand (mul) or divisor (div)
  logic [31:0] rem_q;     // mul: upper product half / div: partial remainder
  logic [31:0] quo_q;     // mul: multiplier shifting out / div: quotient in

  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] fin_hi_s;
  logic [31:0] fin_lo_s;
  logic [32:0] sum_s;
  logic [32:0] sh_s;
  logic [32:0] diff_s;
  logic [63:0] prod_s;

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  // Operand magnitudes for signed ops (Op[0]=1); 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    abs_a_s = OperandA;
    abs_b_s = OperandB;
    if (Op[0] && OperandA[31]) begin
      abs_a_s = 32'd0 - OperandA;
    end else begin
      abs_a_s = OperandA;
    end
    if (Op[0] && OperandB[31]) begin
      abs_b_s = 32'd0 - OperandB;
    end else begin
      abs_b_s = OperandB;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  // The remainder stays below the divisor, so bit 32 of the difference is a
  // reliable borrow flag.
  always_comb begin
    sum_s  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : 33'd0);
    sh_s   = {rem_q, quo_q[31]};
    diff_s = sh_s - {1'b0, b_q};
    rem_d  = rem_q;
    quo_d  = quo_q;
    if (div_q) begin
      if (!diff_s[32]) begin
        rem_d = diff_s[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = sh_s[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end else begin
      rem_d = sum_s[32:1];
      quo_d = {sum_s[0], quo_q[31:1]};
    end
  end

  // Final sign fix-up and divide-by-zero result selection
  always_comb begin
    prod_s   = {rem_q, quo_q};
    fin_hi_s = rem_q;
    fin_lo_s = quo_q;
    if (div_q) begin
      if (dz_q) begin
        fin_hi_s = a_q;
        fin_lo_s = 32'hFFFF_FFFF;
      end else begin
        fin_lo_s = neg_q   ? (32'd0 - quo_q) : quo_q;
        fin_hi_s = rsign_q ? (32'd0 - rem_q) : rem_q;
      end
    end else begin
      if (neg_q) begin
        prod_s = 64'd0 - {rem_q, quo_q};
      end else begin
        prod_s = {rem_q, quo_q};
      end
      fin_hi_s = prod_s[63:32];
      fin_lo_s = prod_s[31:0];
    end
  end

  // Control FSM with registered Busy/Done and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            case (Op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                cnt_q   <= 5'd0;
                div_q   <= Op[1];
                neg_q   <= Op[0] & (OperandA[31] ^ OperandB[31]);
                rsign_q <= Op[0] & OperandA[31];
                dz_q    <= (OperandB == 32'd0);
                a_q     <= OperandA;
                rem_q   <= 32'd0;
                if (Op[1]) begin
                  b_q   <= abs_b_s;
                  quo_q <= abs_a_s;
                end else begin
                  b_q   <= abs_a_s;
                  quo_q <= abs_b_s;
                end
              end
              3'b100: hi_q <= OperandA;
              3'b101: lo_q <= OperandA;
              default: ;
            endcase
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          hi_q    <= fin_hi_s;
          lo_q    <= fin_lo_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed-vector bench for mul_div_unit. Inputs are driven and outputs
//   sampled on the falling edge; the accept edge is edge 1 and results are
//   expected after edge 34.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Start;
  logic [2:0]  Op;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int vectors;
  int miscompares;
  int done_seen;

  mul_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Start    (Start),
    .Op       (Op),
    .Busy     (Busy),
    .Done     (Done),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: presents a request across one rising edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Op       = op;
    OperandA = a;
    OperandB = b;
    Start    = 1'b1;
    @(negedge clk);
    Start    = 1'b0;
  endtask

  // Waits from the falling edge after edge 1 (+skip) to after edge 34.
  task automatic wait_done(input string tag, input int skip, input logic [31:0] hold_hi);
    repeat (32 - skip) @(negedge clk);
    chk({tag, "_done_early"}, {31'd0, Done}, 32'd0);
    chk({tag, "_busy_fin"},   {31'd0, Busy}, 32'd1);
    chk({tag, "_hi_hold"},    Hi, hold_hi);
    @(negedge clk);
    chk({tag, "_done"},       {31'd0, Done}, 32'd1);
    chk({tag, "_busy_end"},   {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    rst         = 1'b1;
    Start       = 1'b0;
    Op          = 3'b000;
    OperandA    = 32'd0;
    OperandB    = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU all-ones squared
    start_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy", {31'd0, Busy}, 32'd1);
    wait_done("multu", 0, 32'd0);
    chk("multu_hi", Hi, 32'hFFFF_FFFE);
    chk("multu_lo", Lo, 32'h0000_0001);
    @(negedge clk);
    chk("multu_done_pulse", {31'd0, Done}, 32'd0);

    // MULT -3 * 7
    start_op(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult", 0, 32'hFFFF_FFFE);
    chk("mult_hi", Hi, 32'hFFFF_FFFF);
    chk("mult_lo", Lo, 32'hFFFF_FFEB);

    // DIV -7 / 2, then DIVU 100 / 0
    @(negedge clk);
    start_op(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 0, 32'hFFFF_FFFF);
    chk("div_lo", Lo, 32'hFFFF_FFFD);
    chk("div_hi", Hi, 32'hFFFF_FFFF);
    @(negedge clk);
    start_op(3'b010, 32'd100, 32'd0);
    wait_done("divu0", 0, 32'hFFFF_FFFF);
    chk("divu0_lo", Lo, 32'hFFFF_FFFF);
    chk("divu0_hi", Hi, 32'd100);

    // Start with new operands during RUN is ignored
    @(negedge clk);
    start_op(3'b010, 32'd100, 32'd7);
    Op       = 3'b000;
    OperandA = 32'd5;
    OperandB = 32'd5;
    Start    = 1'b1;
    @(negedge clk);
    Start    = 1'b0;
    wait_done("ign", 1, 32'd100);
    chk("ign_lo", Lo, 32'd14);
    chk("ign_hi", Hi, 32'd2);

    // Back-to-back Start in the Done cycle
    start_op(3'b000, 32'd3, 32'd4);
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    wait_done("b2b", 0, 32'd2);
    chk("b2b_hi", Hi, 32'd0);
    chk("b2b_lo", Lo, 32'd12);

    // DIV most-negative / -1
    @(negedge clk);
    start_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf", 0, 32'd0);
    chk("ovf_lo", Lo, 32'h8000_0000);
    chk("ovf_hi", Hi, 32'd0);

    // Signed divide by zero: no sign fix-up
    @(negedge clk);
    start_op(3'b011, 32'hFFFF_FFF8, 32'd0);
    wait_done("div0", 0, 32'd0);
    chk("div0_lo", Lo, 32'hFFFF_FFFF);
    chk("div0_hi", Hi, 32'hFFFF_FFF8);

    // MTHI / MTLO / no-op
    @(negedge clk);
    start_op(3'b100, 32'h1234_5678, 32'd0);
    chk("mthi_hi", Hi, 32'h1234_5678);
    chk("mthi_lo", Lo, 32'hFFFF_FFFF);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    chk("mthi_done", {31'd0, Done}, 32'd0);
    start_op(3'b101, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", Lo, 32'hCAFE_F00D);
    chk("mtlo_hi", Hi, 32'h1234_5678);
    start_op(3'b110, 32'hDEAD_BEEF, 32'd1);
    chk("nop_hi", Hi, 32'h1234_5678);
    chk("nop_lo", Lo, 32'hCAFE_F00D);
    chk("nop_busy", {31'd0, Busy}, 32'd0);

    // Reset mid-RUN of DIVU, applied away from the clock edge
    start_op(3'b010, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", {31'd0, Busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    chk("abort_hi_after", Hi, 32'd0);

    // First Start after reset is accepted
    start_op(3'b000, 32'd6, 32'd7);
    chk("post_busy", {31'd0, Busy}, 32'd1);
    wait_done("post", 0, 32'd0);
    chk("post_lo", Lo, 32'd42);
    chk("post_hi", Hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
